display_scan_4dig: RTL and testbench
====================================

DISPLAY_SCAN_4DIG -- requirements
Module: display_scan_4dig

Interface
REQ-001 Parameter CLK_DIV, default 50000: clock cycles per digit slot, legal range 1..2^20.
REQ-002 i_Clk  input  1  sole clock; all state changes on rising edge.
REQ-003 i_Rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_Load  input  1  one-cycle strobe; captures i_Valor.
REQ-005 i_Valor  input  16  four hex digits; [3:0] is digit 0, the rightmost digit.
REQ-006 o_Bits  output  4  nibble of the active digit, fed to the binary-to-7-segment decoder.
REQ-007 o_Anodos  output  4  digit enables, active-low, one-hot-zero; bit n drives digit n.
REQ-008 o_Digito  output  2  index of the active digit.
REQ-009 o_Pend  output  1  high while a captured value waits for the next frame.
REQ-010 o_Frame  output  1  one-cycle pulse on each entry into digit 0.

Function
REQ-011 Prescaler counts 0..CLK_DIV-1 and wraps; tick is asserted when the count equals CLK_DIV-1.
REQ-012 With CLK_DIV=1, tick is asserted every cycle.
REQ-013 On tick, the digit index advances 0->1->2->3->0; no other state sequence exists.
REQ-014 o_Bits, o_Anodos and o_Digito are registered and update in the same edge as the index; no output glitches between slots.
REQ-015 o_Anodos = ~(4'b0001 << index) unless the digit is blanked (REQ-023).
REQ-016 i_Load=1 writes i_Valor into a shadow register and sets o_Pend on the same edge.
REQ-017 On the tick that wraps index 3->0: if o_Pend=1, the shadow value is copied into the display register and o_Pend clears.
REQ-018 Digit 0 of the new frame shows the new value on the same edge as the copy; no frame mixes old and new nibbles.
REQ-019 If i_Load and the wrap tick coincide, i_Valor goes straight into both the shadow and display registers and o_Pend stays 0.
REQ-020 A second i_Load while o_Pend=1 overwrites the shadow (last write wins).
REQ-021 o_Frame pulses for exactly one cycle on the wrap tick, whether or not a copy occurs.

Reset
REQ-022 While i_Rst_n=0, asynchronously and held:
- prescaler = 0, index = 0
- display and shadow registers = 16'h0000
- o_Pend = 0, o_Frame = 0
- o_Bits = 4'h0, o_Digito = 0, o_Anodos = 4'b1110
Reset mid-frame discards any pending value; after release, the first tick comes CLK_DIV cycles later.

Configuration
REQ-023 Macro DISPLAY_SCAN_BLANK_EN defined: digit n (n=3..1) is blanked when it and every higher digit of the display register are zero. A blanked digit drives o_Anodos=4'b1111 in its slot; o_Bits still carries the nibble. Digit 0 is never blanked.
REQ-024 Macro DISPLAY_SCAN_BLANK_EN undefined: no blanking logic is present and all four digits are always enabled per REQ-015.

Structure
REQ-025 Shared package display_pkg holds: NUM_DIG=4, the 2-bit digit-index typedef, the reset anode constant 4'b1110, and the all-off constant 4'b1111.
REQ-026 Prescaler is a sub-module, tick_gen, with parameter CLK_DIV and single-cycle output o_Tick. The index, shadow/display registers and output registers stay in display_scan_4dig.

Verification (CLK_DIV=4 unless stated)
REQ-027 Reset, then pulse i_Load with 16'h1A3F, then wait for o_Frame -> o_Bits F,3,A,1 with o_Anodos 1110,1101,1011,0111, each held 4 cycles, repeating.
REQ-028 Pulse i_Load with 16'h2222 while index=1 -> o_Pend=1 until the wrap, digits 2 and 3 keep the old value, and digit 0 of the next frame shows 2 with o_Pend=0.
REQ-029 i_Load with 16'hBEEF coincident with the wrap tick -> o_Pend stays 0 and digit 0 shows F on that edge.
REQ-030 Drop i_Rst_n mid-slot with index=2 and o_Pend=1 -> outputs reach their reset values without a clock edge; after release, the first index change comes 4 cycles later.
REQ-031 With DISPLAY_SCAN_BLANK_EN, load 16'h0005 -> slots 3..1 drive o_Anodos=1111 and slot 0 drives 1110 with o_Bits=5. Load 16'h0000 -> only digit 0 is lit, showing 0.
REQ-032 CLK_DIV=1 -> index advances every cycle and o_Frame pulses every 4th cycle.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants and types for the four-digit multiplexed display scanner.
package display_pkg;

    localparam int NUM_DIG = 4;

    typedef logic [1:0] digit_idx_t;

    localparam logic [3:0] ANODE_RESET = 4'b1110;
    localparam logic [3:0] ANODE_OFF   = 4'b1111;

    // Active-low one-hot enable for the given digit slot.
    function automatic logic [3:0] anode_for(input digit_idx_t idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: counts 0..CLK_DIV-1 and flags the last count with a one-cycle tick.
module tick_gen #(
    parameter int CLK_DIV = 50000
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    output logic o_Tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] count_reg;

    // With CLK_DIV=1 the counter sits at 0, which is also LAST, so tick stays high.
    assign o_Tick = (count_reg == LAST);

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            count_reg <= '0;
        end else if (o_Tick) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CW'(1);
        end
    end

endmodule

// File: rtl/display_scan_4dig.sv
// Four-digit display scanner with double-buffered value, swapped only at frame wrap.
// Optional leading-zero blanking is enabled by defining DISPLAY_SCAN_BLANK_EN.
module display_scan_4dig
    import display_pkg::*;
#(
    parameter int CLK_DIV = 50000
) (
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic        i_Load,
    input  logic [15:0] i_Valor,
    output logic [3:0]  o_Bits,
    output logic [3:0]  o_Anodos,
    output logic [1:0]  o_Digito,
    output logic        o_Pend,
    output logic        o_Frame
);

    logic        tick;
    logic        wrap;
    digit_idx_t  index_reg, index_next;
    logic [15:0] shadow_reg, shadow_next;
    logic [15:0] display_reg, display_next;
    logic        pend_reg, pend_next;
    logic        frame_reg;
    logic [3:0]  bits_reg, bits_next;
    logic [3:0]  anodes_reg, anodes_next;

    tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .o_Tick  (tick)
    );

    assign wrap       = tick && (index_reg == 2'd3);
    assign index_next = tick ? index_reg + 2'd1 : index_reg;

    // A load on the wrap tick bypasses the shadow so the new frame starts with it.
    always_comb begin
        shadow_next  = shadow_reg;
        display_next = display_reg;
        pend_next    = pend_reg;
        if (i_Load) begin
            shadow_next = i_Valor;
            pend_next   = 1'b1;
        end
        if (wrap) begin
            if (i_Load) begin
                display_next = i_Valor;
            end else if (pend_reg) begin
                display_next = shadow_reg;
            end
            pend_next = 1'b0;
        end
    end

    // Outputs are computed from next-state values so they change on the same edge as the index.
    assign bits_next = display_next[{index_next, 2'b00} +: 4];

`ifdef DISPLAY_SCAN_BLANK_EN
    logic [NUM_DIG-1:0] blank;

    assign blank[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < NUM_DIG; gi++) begin : g_blank
            assign blank[gi] = (display_next[4*NUM_DIG-1:4*gi] == '0);
        end
    endgenerate

    assign anodes_next = blank[index_next] ? ANODE_OFF : anode_for(index_next);
`else
    assign anodes_next = anode_for(index_next);
`endif

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            index_reg   <= '0;
            shadow_reg  <= '0;
            display_reg <= '0;
            pend_reg    <= 1'b0;
            frame_reg   <= 1'b0;
            bits_reg    <= '0;
            anodes_reg  <= ANODE_RESET;
        end else begin
            index_reg   <= index_next;
            shadow_reg  <= shadow_next;
            display_reg <= display_next;
            pend_reg    <= pend_next;
            frame_reg   <= wrap;
            bits_reg    <= bits_next;
            anodes_reg  <= anodes_next;
        end
    end

    assign o_Bits   = bits_reg;
    assign o_Anodos = anodes_reg;
    assign o_Digito = index_reg;
    assign o_Pend   = pend_reg;
    assign o_Frame  = frame_reg;

endmodule

// File: tb/tb_display_scan_4dig.sv
// Scoreboard bench: each load pushes the frame value it should produce; every frame pops and checks all 16 cycles.
module tb_display_scan_4dig;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] valor = '0;
    logic [3:0]  o_Bits, o_Anodos;
    logic [1:0]  o_Digito;
    logic        o_Pend, o_Frame;

    logic        rst1_n = 1'b0;
    logic        load1 = 1'b0;
    logic [15:0] valor1 = '0;
    logic [3:0]  bits1, anodes1;
    logic [1:0]  digito1;
    logic        pend1, frame1;

    int total = 0;
    int bad = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    display_scan_4dig #(.CLK_DIV(4)) u_dut (
        .i_Clk    (clk),
        .i_Rst_n  (rst_n),
        .i_Load   (load),
        .i_Valor  (valor),
        .o_Bits   (o_Bits),
        .o_Anodos (o_Anodos),
        .o_Digito (o_Digito),
        .o_Pend   (o_Pend),
        .o_Frame  (o_Frame)
    );

    display_scan_4dig #(.CLK_DIV(1)) u_dut1 (
        .i_Clk    (clk),
        .i_Rst_n  (rst1_n),
        .i_Load   (load1),
        .i_Valor  (valor1),
        .o_Bits   (bits1),
        .o_Anodos (anodes1),
        .o_Digito (digito1),
        .o_Pend   (pend1),
        .o_Frame  (frame1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_anodes(input logic [15:0] v, input int d);
        logic [3:0] a;
        a    = 4'b1111;
        a[d] = 1'b0;
`ifdef DISPLAY_SCAN_BLANK_EN
        if (d > 0 && (v >> (4 * d)) == 16'h0) a = 4'b1111;
`endif
        return a;
    endfunction

    task automatic check_reset(input string pfx);
        check({pfx, "_bits"},   o_Bits,   4'h0);
        check({pfx, "_anodes"}, o_Anodos, 4'b1110);
        check({pfx, "_digito"}, o_Digito, 2'd0);
        check({pfx, "_pend"},   o_Pend,   1'b0);
        check({pfx, "_frame"},  o_Frame,  1'b0);
    endtask

    task automatic wait_frame();
        int n = 0;
        while (o_Frame !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("frame_seen", o_Frame, 1'b1);
    endtask

    // Called at the negedge of the first cycle of a frame; optionally pulses load at cycle load_at.
    task automatic run_frame(input int load_at, input logic [15:0] load_val);
        logic [15:0] cur;
        bit loaded;
        loaded = 1'b0;
        check("queue_size", exp_q.size(), 1);
        cur = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        for (int c = 0; c < 16; c++) begin
            int d;
            d = c / 4;
            check($sformatf("bits_%04h_c%0d", cur, c), o_Bits, (cur >> (4 * d)) & 16'hF);
            check($sformatf("anodes_%04h_c%0d", cur, c), o_Anodos, exp_anodes(cur, d));
            check($sformatf("digito_%04h_c%0d", cur, c), o_Digito, d);
            check($sformatf("frame_%04h_c%0d", cur, c), o_Frame, (c == 0));
            check($sformatf("pend_%04h_c%0d", cur, c), o_Pend, (load_at >= 0 && c > load_at));
            if (c == load_at) begin
                load  = 1'b1;
                valor = load_val;
                exp_q.push_back(load_val);
                loaded = 1'b1;
            end
            @(negedge clk);
            load = 1'b0;
        end
        if (!loaded) exp_q.push_back(cur);
        $display("frame %04h: 16 cycles checked (load_at=%0d)", cur, load_at);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check_reset("reset_held");

        rst_n = 1'b1;
        @(negedge clk);
        load  = 1'b1;
        valor = 16'h1A3F;
        exp_q.push_back(16'h1A3F);
        @(negedge clk);
        load = 1'b0;
        check("pend_after_load", o_Pend, 1'b1);
        $display("load 1a3f before first frame");

        wait_frame();
        run_frame(-1, 16'h0);
        run_frame(-1, 16'h0);
        run_frame(5, 16'h2222);
        run_frame(-1, 16'h0);
        run_frame(15, 16'hBEEF);
        run_frame(-1, 16'h0);
        run_frame(7, 16'h0005);
        run_frame(-1, 16'h0);
        run_frame(3, 16'h0000);
        run_frame(-1, 16'h0);

        // Mid-slot asynchronous reset with a value pending at index 2.
        load  = 1'b1;
        valor = 16'hABCD;
        @(negedge clk);
        load = 1'b0;
        repeat (7) @(negedge clk);
        check("pre_reset_digito", o_Digito, 2'd2);
        check("pre_reset_pend", o_Pend, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_reset("async_reset");
        $display("async reset mid-slot applied");
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        exp_q.push_back(16'h0000);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("post_reset_digito_k%0d", k), o_Digito, (k < 4) ? 2'd0 : 2'd1);
        end
        wait_frame();
        run_frame(-1, 16'h0);

        // CLK_DIV=1 instance: index steps every cycle, frame every 4th.
        @(negedge clk);
        rst1_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check($sformatf("div1_digito_k%0d", k), digito1, k % 4);
            check($sformatf("div1_frame_k%0d", k), frame1, (k % 4) == 0);
            check($sformatf("div1_anodes_k%0d", k), anodes1, exp_anodes(16'h0, k % 4));
            check($sformatf("div1_bits_k%0d", k), bits1, 4'h0);
            check($sformatf("div1_pend_k%0d", k), pend1, 1'b0);
        end
        $display("clk_div=1 scan checked");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
